lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent waiting for mem_gnt or mem_rvalid before aborting; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 req_valid  input  1  pipeline memory-stage request present.
REQ-005 req_ready  output  1  lsu accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I load/store funct3.
REQ-008 req_addr  input  32  byte address (ALU result).
REQ-009 req_wdata  input  32  store data, unaligned, in low bits.
REQ-010 stall  output  1  equals req_valid AND NOT req_ready; drives pipeline stall.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 rsp_err  output  1  qualifies rsp_valid; access failed.
REQ-014 mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-015 mem_addr  output  32  word address {req_addr[31:2],2'b00}.
REQ-016 mem_be  output  4  byte enables; mem_wdata  output  32  lane-replicated data.
REQ-017 mem_gnt, mem_rvalid  input  1 each; mem_rdata  input  32  full word read data.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, RSP, DONE; req_ready = 1 only in IDLE.
REQ-019 On acceptance (IDLE, req_valid) the lsu SHALL register we/funct3/addr/wdata and move to REQ, or to DONE with error for illegal funct3 (load 3,6,7; store 3..7) with no memory access.
REQ-020 In REQ the lsu SHALL hold mem_req=1 with stable mem_we/mem_addr/mem_be/mem_wdata until mem_gnt=1.
REQ-021 On grant, a store SHALL go to DONE; a load SHALL go to RSP; mem_req deasserts the cycle after grant.
REQ-022 In RSP, mem_rvalid=1 SHALL capture the extracted data and go to DONE; mem_rvalid seen in IDLE or REQ SHALL be ignored.
REQ-023 DONE SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; a new request is acceptable the following cycle.
REQ-024 Byte enables SHALL be: sb 4'b0001<<addr[1:0]; sh addr[1]?4'b1100:4'b0011; sw 4'b1111; loads 4'b1111.
REQ-025 mem_wdata SHALL be: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
REQ-026 Load data SHALL select the byte by addr[1:0] (lb sign-, lbu zero-extended) and the half by addr[1] (lh sign-, lhu zero-extended); lw passes the word.
REQ-027 A 8-bit counter SHALL clear on entering REQ and RSP and increment each cycle there; reaching TIMEOUT SHALL drop mem_req and go to DONE with rsp_err=1, rsp_rdata=0.
REQ-028 Minimum latency: accept at cycle T, grant at T+1, store rsp_valid at T+2; load with rvalid at T+2 gives rsp_valid at T+3.

Reset
REQ-029 With rst_n=0 at a clock edge: state IDLE, counter 0, mem_req, mem_we, rsp_valid, rsp_err = 0, rsp_rdata, mem_be, mem_wdata, mem_addr = 0.
REQ-030 Reset mid-transaction SHALL abandon it with no rsp_valid; a late mem_rvalid afterwards SHALL be ignored.

Configuration
REQ-031 Macro LSU_MISALIGN_CHECK_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, SHALL skip memory and go directly to DONE with rsp_err=1.
REQ-032 Macro undefined: such accesses SHALL proceed, with halfword using addr[1] only and word ignoring addr[1:0]; rsp_err only for illegal funct3 or timeout.

Verification
REQ-033 sb addr 0x103, wdata 0xAB, gnt immediate -> mem_be 4'b1000, mem_wdata 0xABABABAB, mem_addr 0x100, rsp_valid at T+2, rsp_err 0.
REQ-034 lb addr 0x102, mem_rdata 0x0080FF00, rvalid at T+2 -> rsp_rdata 0xFFFFFF80 at T+3; lbu same -> 0x00000080.
REQ-035 lh addr 0x102, mem_rdata 0x8001_1234 -> rsp_rdata 0xFFFF8001; lhu -> 0x00008001.
REQ-036 TIMEOUT=4, gnt held 0 -> mem_req high 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata 0; later rvalid ignored.
REQ-037 lw addr 0x102: with LSU_MISALIGN_CHECK_EN -> no mem_req, rsp_err=1 at T+1; without it -> mem_addr 0x100, normal response.
REQ-038 rst_n=0 while in RSP -> next cycle IDLE, req_ready=1, no rsp_valid; back-to-back stores complete every 3 cycles with immediate grant.

Source files
------------

// File: rtl/lsu_if.sv
// Pipeline-side request/response and memory-side bus of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; memory grants when mem_req && mem_gnt.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be,
           mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be,
           mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit with one outstanding access and a grant/read-valid timeout.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses without a memory access.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_if.slave       bus,
  output logic [1:0] dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, DONE = 2'd3} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        err_q;
  logic [7:0]  cnt;
  logic        illegal, misalign, expired;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data, store_data;
  logic [3:0]  be;

  always_comb begin
    if (bus.req_we) illegal = bus.req_funct3 > 3'd2;
    else            illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 >= 3'd6);
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = bus.req_addr[1:0] != 2'b00;
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // The last waiting cycle still honours a grant/rvalid; the abort happens only without one.
  assign expired = cnt == LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.req_valid) state_nx = (illegal || misalign) ? DONE : REQ;
      REQ:  if (bus.mem_gnt) state_nx = we_q ? DONE : RSP;
            else if (expired) state_nx = DONE;
      RSP:  if (bus.mem_rvalid || expired) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      cnt      <= 8'd0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q     <= bus.req_we;
          funct3_q <= bus.req_funct3;
          addr_q   <= bus.req_addr;
          wdata_q  <= bus.req_wdata;
          rdata_q  <= 32'd0;
          err_q    <= illegal || misalign;
          cnt      <= 8'd0;
        end
        REQ: begin
          if (bus.mem_gnt)  cnt   <= 8'd0;
          else if (expired) err_q <= 1'b1;
          else              cnt   <= cnt + 8'd1;
        end
        RSP: begin
          if (bus.mem_rvalid) rdata_q <= load_data;
          else if (expired)   err_q   <= 1'b1;
          else                cnt     <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign byte_sel = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    case (funct3_q)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {24'd0, byte_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        store_data = {4{wdata_q[7:0]}};
        be         = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        store_data = {2{wdata_q[15:0]}};
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = wdata_q;
        be         = 4'b1111;
      end
    endcase
    if (!we_q) be = 4'b1111;
  end

  // Memory-side fields are zero outside REQ so the bus is quiet between accesses.
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.stall     = bus.req_valid && (state != IDLE);
    bus.mem_req   = state == REQ;
    bus.mem_we    = (state == REQ) && we_q;
    bus.mem_addr  = (state == REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
    bus.mem_be    = (state == REQ) ? be : 4'd0;
    bus.mem_wdata = (state == REQ) ? store_data : 32'd0;
    bus.rsp_valid = state == DONE;
    bus.rsp_err   = (state == DONE) && err_q;
    bus.rsp_rdata = (state == DONE) ? rdata_q : 32'd0;
    dbg_state     = state;
  end
endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu: the driver acts as pipeline and memory, monitors pop expectations.
module tb_lsu;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  lsu_if      bus();

  lsu #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  int req_cycles = 0;
  int last_t = 0;

  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [68:0] exp_mem_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference model: access legality and load result from the ISA rules, using plain arithmetic.
  function automatic bit imm_err(input bit we, input bit [2:0] f3, input bit [31:0] addr);
    bit legal;
    bit mis;
    int sz;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    sz = 1 << f3[1:0];
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (legal) mis = (addr % sz) != 0;
`endif
    return !legal || mis;
  endfunction

  function automatic bit [31:0] load_val(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] mdata);
    int sz, off, bits;
    longint v, m;
    sz = 1 << f3[1:0];
    off = (addr % 4) / sz * sz;
    bits = 8 * sz;
    m = mdata;
    v = (m >> (8 * off)) % (64'd1 << bits);
    if (!f3[2] && sz < 4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.req_ready;
    if (!ok) fail_now("ready_wait", "req_ready never asserted");
  endtask

  task automatic run_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata,
                         input bit [31:0] mdata, input int gd, input int rd, input int gap, input bit poke);
    bit ok, ie, e_err;
    bit [31:0] e_rd, e_wd;
    bit [3:0] e_be;
    int sz, off, t, e_cyc;
    wait_ready(ok);
    if (!ok) return;
    ie = imm_err(we, f3, addr);
    sz = 1 << f3[1:0];
    off = (addr % 4) / sz * sz;
    e_err = ie || gd >= TO || (!we && rd >= TO);
    e_rd = (e_err || we) ? 32'd0 : load_val(f3, addr, mdata);
    t = cyc;
    if (ie)            e_cyc = t + 1;
    else if (gd >= TO) e_cyc = t + 1 + TO;
    else if (we)       e_cyc = t + 2 + gd;
    else if (rd >= TO) e_cyc = t + 2 + gd + TO;
    else               e_cyc = t + 3 + gd + rd;
    exp_q.push_back({e_err, e_rd});
    exp_cyc_q.push_back(e_cyc);
    if (!ie && gd < TO) begin
      e_be = we ? 4'(((1 << sz) - 1) << off) : 4'hF;
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
      exp_mem_q.push_back({we, addr & 32'hFFFF_FFFC, e_be, e_wd});
    end
    last_t = t;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (!ie) begin
      for (int k = 0; k < TO; k++) begin
        bus.mem_gnt = (k == gd);
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        if (k == 0 && poke) bus.req_valid = 1'b1;
        @(negedge clk);
        if (k == 0 && poke) check("stall_busy", {bus.stall, bus.req_ready}, 2'b10);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (k == gd) break;
      end
      if (!we && gd < TO) begin
        for (int k = 0; k < TO; k++) begin
          bus.mem_rvalid = (k == rd);
          bus.mem_rdata = (k == rd) ? mdata : $urandom;
          @(posedge clk); #1;
          bus.mem_rvalid = 1'b0;
          if (k == rd) break;
        end
      end
    end
    repeat (gap) begin
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
    end
  endtask

  // Monitors: memory requests checked at grant, responses checked at rsp_valid.
  always @(negedge clk) begin
    logic [68:0] em;
    logic [32:0] er;
    int ec;
    if (bus.mem_req) req_cycles++;
    if (rst_n && bus.mem_req && bus.mem_gnt) begin
      if (exp_mem_q.size() == 0) fail_now("mem_unexpected", "grant with no expected memory access");
      else begin
        em = exp_mem_q.pop_front();
        check("mem_we", bus.mem_we, em[68]);
        check("mem_addr", bus.mem_addr, em[67:36]);
        check("mem_be", bus.mem_be, em[35:32]);
        if (em[68]) check("mem_wdata", bus.mem_wdata, em[31:0]);
      end
    end
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) fail_now("rsp_unexpected", "rsp_valid with no outstanding request");
      else begin
        er = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("rsp_err", bus.rsp_err, er[32]);
        check("rsp_rdata", bus.rsp_rdata, er[31:0]);
        check("rsp_cycle", cyc, ec);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t1, gd, rd;
    bit we;
    bit [2:0] f3;
    bit [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", bus.req_ready, 1'b1);
    check("reset_mem_ctl", {bus.mem_req, bus.mem_we, bus.mem_be}, 6'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);
    check("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b1, 3'd0, 32'h103, 32'hAB, 32'd0, 0, 0, 1, 1'b0);
    run_txn(1'b0, 3'd0, 32'h102, 32'd0, 32'h0080FF00, 0, 0, 1, 1'b0);
    run_txn(1'b0, 3'd4, 32'h102, 32'd0, 32'h0080FF00, 0, 0, 1, 1'b0);
    run_txn(1'b0, 3'd1, 32'h102, 32'd0, 32'h80011234, 1, 2, 1, 1'b1);
    run_txn(1'b0, 3'd5, 32'h102, 32'd0, 32'h80011234, 0, 0, 1, 1'b0);
    run_txn(1'b0, 3'd2, 32'h102, 32'd0, 32'hDEADBEEF, 0, 0, 1, 1'b0);
    run_txn(1'b1, 3'd1, 32'h206, 32'h1234_5678, 32'd0, 2, 0, 0, 1'b0);
    run_txn(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 0, 0, 0, 1'b0);
    run_txn(1'b1, 3'd5, 32'h100, 32'h55, 32'd0, 0, 0, 0, 1'b0);

    req_cycles = 0;
    run_txn(1'b0, 3'd2, 32'h300, 32'd0, 32'h1111_2222, TO, 0, 0, 1'b0);
    check("timeout_mem_req_cycles", req_cycles, TO);
    run_txn(1'b0, 3'd2, 32'h304, 32'd0, 32'h3333_4444, 0, TO, 0, 1'b0);
    wait_ready(ok);
    bus.mem_rvalid = 1'b1;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;

    run_txn(1'b1, 3'd2, 32'h400, 32'hCAFE_F00D, 32'd0, 0, 0, 0, 1'b0);
    t1 = last_t;
    run_txn(1'b1, 3'd2, 32'h404, 32'h0BAD_F00D, 32'd0, 0, 0, 0, 1'b0);
    check("back_to_back_spacing", last_t - t1, 3);

    wait_ready(ok);
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h200;
    bus.req_valid = 1'b1;
    exp_mem_q.push_back({1'b0, 32'h200, 4'hF, 32'h0});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    check("rsp_state_busy", bus.req_ready, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_reset_idle", {bus.req_ready, bus.rsp_valid, bus.mem_req}, 3'b100);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    check("late_rvalid_ignored", {bus.req_ready, bus.rsp_valid}, 2'b10);

    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      gd = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      rd = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      run_txn(we, f3, $urandom, $urandom, $urandom, gd, rd, $urandom_range(0, 2),
              1'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    check("rsp_queue_drained", exp_q.size(), 0);
    check("mem_queue_drained", exp_mem_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
